// File: rtl/dp32_acc_if.sv
// Beat/result handshake bundle between a dp32 producer, the dp32_acc
// accumulator and the consumer of finished dot products.
interface dp32_acc_if #(
  parameter int ACC_W = 72,
  parameter int CNT_W = 16
);
  // Input beat side
  logic [2:0]       mode;
  logic             in_valid;
  logic             in_ready;
  logic             in_last;
  logic [63:0]      mul_int32;
  logic [32:0]      sum_int16;
  logic [17:0]      sum_int8;
  logic [10:0]      sum_int4;
  logic [7:0]       sum_int2;
  // Result side
  logic [ACC_W-1:0] acc_out;
  logic [CNT_W-1:0] beats;
  logic             ovf;
  logic             mode_err;
  logic             out_valid;
  logic             out_ready;

  // Environment side: feeds beats, consumes results
  modport master (
    output mode, in_valid, in_last, mul_int32, sum_int16, sum_int8,
           sum_int4, sum_int2, out_ready,
    input  in_ready, acc_out, beats, ovf, mode_err, out_valid
  );

  // Accumulator side
  modport slave (
    input  mode, in_valid, in_last, mul_int32, sum_int16, sum_int8,
           sum_int4, sum_int2, out_ready,
    output in_ready, acc_out, beats, ovf, mode_err, out_valid
  );
endinterface

// File: rtl/dp32_acc.sv
// dp32_acc: accumulates dp32 lane sums, one per accepted beat, into a wide
// register until a last-flagged beat, then holds the dot product on the
// output handshake until the consumer takes it.
module dp32_acc #(
  parameter int ACC_W = 72,
  parameter int CNT_W = 16
) (
  input  logic     CLK,
  input  logic     rst,
  dp32_acc_if.slave bus
);
  localparam int EXT_W = ACC_W + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACC  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [2:0]       r_mode;
  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_beats;
  logic             r_ovf;
  logic             r_mode_err;

  logic             w_in_ready;
  logic             w_accept;
  logic [2:0]       w_sel_mode;
  logic [EXT_W-1:0] w_sel;
  logic [EXT_W-1:0] w_sum;

  // The first beat of a vector is steered by the mode port; later beats use
  // the mode latched at that first beat so mid-vector mode changes are inert.
  assign w_in_ready = (r_state == S_IDLE) || (r_state == S_ACC);
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_sel_mode = (r_state == S_IDLE) ? bus.mode : r_mode;
  assign w_sum      = {1'b0, r_acc} + w_sel;

  // Pick the lane sum for the active precision, zero-extended; illegal modes add 0
  always_comb begin
    // NOTE: default assignment first so no path through the case leaves w_sel unassigned (no latch).
    w_sel = '0;
    case (w_sel_mode)
      3'd0:    w_sel = EXT_W'(bus.mul_int32);
      3'd1:    w_sel = EXT_W'(bus.sum_int16);
      3'd2:    w_sel = EXT_W'(bus.sum_int8);
      3'd3:    w_sel = EXT_W'(bus.sum_int4);
      3'd4:    w_sel = EXT_W'(bus.sum_int2);
      default: w_sel = '0;
    endcase
  end

  // Vector FSM: start on first beat, accumulate, hold result until taken
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_mode     <= 3'd0;
      r_acc      <= '0;
      r_beats    <= '0;
      r_ovf      <= 1'b0;
      r_mode_err <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_mode     <= bus.mode;
            r_acc      <= w_sel[ACC_W-1:0];
            r_beats    <= CNT_W'(1);
            r_ovf      <= 1'b0;
            r_mode_err <= (bus.mode > 3'd4);
            r_state    <= bus.in_last ? S_DONE : S_ACC;
          end
        end
        S_ACC: begin
          if (w_accept) begin
            r_acc <= w_sum[ACC_W-1:0];
            r_ovf <= r_ovf | w_sum[ACC_W];
            if (r_beats != {CNT_W{1'b1}}) begin
              r_beats <= r_beats + CNT_W'(1);
            end
            if (bus.in_last) begin
              r_state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            r_state    <= S_IDLE;
            r_acc      <= '0;
            r_beats    <= '0;
            r_ovf      <= 1'b0;
            r_mode_err <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.acc_out   = r_acc;
  assign bus.beats     = r_beats;
  assign bus.ovf       = r_ovf;
  assign bus.mode_err  = r_mode_err;
endmodule

// File: tb/tb_dp32_acc.sv
// Directed bench for dp32_acc: a 72-bit instance for most scenarios and a
// 64-bit instance to reach the accumulator carry-out.
module tb_dp32_acc;
  logic CLK = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  dp32_acc_if #(.ACC_W(72), .CNT_W(16)) bus ();
  dp32_acc_if #(.ACC_W(64), .CNT_W(16)) b64 ();

  dp32_acc #(.ACC_W(72), .CNT_W(16)) dut   (.CLK(CLK), .rst(rst), .bus(bus));
  dp32_acc #(.ACC_W(64), .CNT_W(16)) dut64 (.CLK(CLK), .rst(rst), .bus(b64));

  always #5 CLK = ~CLK;

  task automatic clear_inputs();
    bus.mode = 3'd0; bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.out_ready = 1'b0;
    bus.mul_int32 = '0; bus.sum_int16 = '0; bus.sum_int8 = '0;
    bus.sum_int4 = '0; bus.sum_int2 = '0;
    b64.mode = 3'd0; b64.in_valid = 1'b0; b64.in_last = 1'b0; b64.out_ready = 1'b0;
    b64.mul_int32 = '0; b64.sum_int16 = '0; b64.sum_int8 = '0;
    b64.sum_int4 = '0; b64.sum_int2 = '0;
  endtask

  // Present one beat on the 72-bit instance and hold it until accepted
  task automatic send_beat(input logic last);
    int waited = 0;
    bus.in_valid = 1'b1;
    bus.in_last  = last;
    while (bus.in_ready !== 1'b1 && waited < 20) begin
      @(posedge CLK); #1;
      waited++;
    end
    total++;
    if (waited >= 20) begin
      bad++;
      $display("FAIL beat_timeout: in_ready=%b required 1", bus.in_ready);
    end
    @(posedge CLK); #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic take_result();
    bus.out_ready = 1'b1;
    @(posedge CLK); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    total++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_hs: out_valid=%b in_ready=%b required 0/1", bus.out_valid, bus.in_ready);
    end
    total++;
    if (bus.acc_out !== 72'd0 || bus.beats !== 16'd0 || bus.ovf !== 1'b0 || bus.mode_err !== 1'b0) begin
      bad++;
      $display("FAIL reset_regs: acc=%h beats=%0d ovf=%b merr=%b required 0/0/0/0",
               bus.acc_out, bus.beats, bus.ovf, bus.mode_err);
    end
  endtask

  task automatic test_int32_single();
    bus.mode = 3'd0;
    bus.mul_int32 = 64'hFFFFFFFE00000001;
    send_beat(1'b1);
    total++;
    if (bus.out_valid !== 1'b1) begin
      bad++;
      $display("FAIL int32_valid: out_valid=%b required 1", bus.out_valid);
    end
    total++;
    if (bus.acc_out !== 72'h00FFFFFFFE00000001 || bus.beats !== 16'd1 || bus.ovf !== 1'b0) begin
      bad++;
      $display("FAIL int32_result: acc=%h beats=%0d ovf=%b required 00fffffffe00000001/1/0",
               bus.acc_out, bus.beats, bus.ovf);
    end
    take_result();
    total++;
    if (bus.out_valid !== 1'b0 || bus.acc_out !== 72'd0) begin
      bad++;
      $display("FAIL int32_release: out_valid=%b acc=%h required 0/0", bus.out_valid, bus.acc_out);
    end
  endtask

  task automatic test_int2_three_beats();
    bus.mode = 3'd4;
    bus.sum_int2 = 8'h90;
    send_beat(1'b0);
    // in_last without in_valid must not end the vector
    bus.in_last = 1'b1;
    @(posedge CLK); #1;
    bus.in_last = 1'b0;
    total++;
    if (bus.out_valid !== 1'b0 || bus.beats !== 16'd1) begin
      bad++;
      $display("FAIL int2_idle_last: out_valid=%b beats=%0d required 0/1", bus.out_valid, bus.beats);
    end
    send_beat(1'b0);
    send_beat(1'b1);
    total++;
    if (bus.acc_out !== 72'd432 || bus.beats !== 16'd3) begin
      bad++;
      $display("FAIL int2_result: acc=%0d beats=%0d required 432/3", bus.acc_out, bus.beats);
    end
    total++;
    if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
      bad++;
      $display("FAIL int2_hs: out_valid=%b in_ready=%b required 1/0", bus.out_valid, bus.in_ready);
    end
  endtask

  // Continues from the held int2 result
  task automatic test_backpressure();
    bus.in_valid = 1'b1;
    bus.in_last  = 1'b1;
    bus.sum_int2 = 8'h01;
    for (int i = 0; i < 5; i++) begin
      @(posedge CLK); #1;
      total++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
          bus.acc_out !== 72'd432 || bus.beats !== 16'd3) begin
        bad++;
        $display("FAIL bp_hold[%0d]: out_valid=%b in_ready=%b acc=%0d beats=%0d required 1/0/432/3",
                 i, bus.out_valid, bus.in_ready, bus.acc_out, bus.beats);
      end
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    take_result();
    total++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 ||
        bus.acc_out !== 72'd0 || bus.beats !== 16'd0) begin
      bad++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b acc=%0d beats=%0d required 0/1/0/0",
               bus.out_valid, bus.in_ready, bus.acc_out, bus.beats);
    end
  endtask

  task automatic test_overflow64();
    b64.mode      = 3'd0;
    b64.mul_int32 = 64'hFFFFFFFE00000001;
    b64.in_valid  = 1'b1;
    b64.in_last   = 1'b0;
    @(posedge CLK); #1;
    b64.in_last   = 1'b1;
    @(posedge CLK); #1;
    b64.in_valid  = 1'b0;
    b64.in_last   = 1'b0;
    total++;
    if (b64.out_valid !== 1'b1 || b64.acc_out !== 64'hFFFFFFFC00000002 ||
        b64.ovf !== 1'b1 || b64.beats !== 16'd2) begin
      bad++;
      $display("FAIL ovf64: out_valid=%b acc=%h ovf=%b beats=%0d required 1/fffffffc00000002/1/2",
               b64.out_valid, b64.acc_out, b64.ovf, b64.beats);
    end
    b64.out_ready = 1'b1;
    @(posedge CLK); #1;
    b64.out_ready = 1'b0;
    total++;
    if (b64.ovf !== 1'b0 || b64.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL ovf64_clear: ovf=%b out_valid=%b required 0/0", b64.ovf, b64.out_valid);
    end
  endtask

  task automatic test_mode_latch();
    bus.mode      = 3'd2;
    bus.sum_int8  = 18'h3F804;
    bus.sum_int16 = 33'h1FFFC0002;
    send_beat(1'b0);
    bus.mode = 3'd1;
    send_beat(1'b1);
    total++;
    if (bus.acc_out !== 72'h7F008 || bus.beats !== 16'd2 || bus.mode_err !== 1'b0) begin
      bad++;
      $display("FAIL mode_latch: acc=%h beats=%0d merr=%b required 7f008/2/0",
               bus.acc_out, bus.beats, bus.mode_err);
    end
    take_result();
  endtask

  task automatic test_reset_mid_vector();
    bus.mode      = 3'd0;
    bus.mul_int32 = 64'd5;
    send_beat(1'b0);
    send_beat(1'b0);
    rst = 1'b1;
    #2;
    total++;
    if (bus.acc_out !== 72'd0 || bus.beats !== 16'd0 || bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL rst_async: acc=%0d beats=%0d in_ready=%b required 0/0/1",
               bus.acc_out, bus.beats, bus.in_ready);
    end
    @(posedge CLK); #1;
    rst = 1'b0;
    bus.mode     = 3'd3;
    bus.sum_int4 = 11'h708;
    send_beat(1'b1);
    total++;
    if (bus.out_valid !== 1'b1 || bus.acc_out !== 72'h708 || bus.beats !== 16'd1 ||
        bus.ovf !== 1'b0 || bus.mode_err !== 1'b0) begin
      bad++;
      $display("FAIL rst_then_int4: valid=%b acc=%h beats=%0d ovf=%b merr=%b required 1/708/1/0/0",
               bus.out_valid, bus.acc_out, bus.beats, bus.ovf, bus.mode_err);
    end
    take_result();
  endtask

  task automatic test_illegal_mode();
    bus.mode      = 3'd6;
    bus.mul_int32 = 64'h1234;
    bus.sum_int2  = 8'hFF;
    send_beat(1'b1);
    total++;
    if (bus.out_valid !== 1'b1 || bus.acc_out !== 72'd0 ||
        bus.mode_err !== 1'b1 || bus.beats !== 16'd1) begin
      bad++;
      $display("FAIL illegal_mode: valid=%b acc=%h merr=%b beats=%0d required 1/0/1/1",
               bus.out_valid, bus.acc_out, bus.mode_err, bus.beats);
    end
    take_result();
    total++;
    if (bus.mode_err !== 1'b0) begin
      bad++;
      $display("FAIL illegal_clear: merr=%b required 0", bus.mode_err);
    end
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    #12;
    rst = 1'b0;
    @(posedge CLK); #1;
    test_reset();
    test_int32_single();
    test_int2_three_beats();
    test_backpressure();
    test_overflow64();
    test_mode_latch();
    test_reset_mid_vector();
    test_illegal_mode();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dp32_acc.md
Name: dp32_acc

Overview:
Sequential consumer for the dp32 SIMD multiplier outputs. It accepts one dp32 result per beat over a valid/ready handshake and selects the lane sum for the active precision mode. It accumulates beats into a wide register until a last-flagged beat arrives, then presents the vector dot product on an output valid/ready port. It sits directly downstream of dp32 and turns single-word SIMD products into arbitrary-length dot products.

Parameters:
ACC_W, 72, accumulator and result width in bits; legal range 64 to 128.
CNT_W, 16, beat-counter width in bits.

Ports:
CLK  input  1  clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-high reset.
mode  input  3  precision select: 0=int32 (mul_int32), 1=int16 (sum_int16), 2=int8 (sum_int8), 3=int4 (sum_int4), 4=int2 (sum_int2); values 5-7 are illegal.
in_valid  input  1  input beat valid.
in_ready  output  1  block can accept a beat.
in_last  input  1  final beat of the vector.
mul_int32  input  64  dp32 int32 product.
sum_int16  input  33  dp32 int16 lane sum.
sum_int8  input  18  dp32 int8 lane sum.
sum_int4  input  11  dp32 int4 lane sum.
sum_int2  input  8  dp32 int2 lane sum.
acc_out  output  ACC_W  accumulated dot product.
beats  output  CNT_W  number of beats in the reported vector.
ovf  output  1  sticky flag: accumulator carry-out occurred in this vector.
mode_err  output  1  sticky flag: an illegal mode was seen at the first beat of this vector.
out_valid  output  1  result valid.
out_ready  input  1  downstream accepts the result.

Behaviour:
- Reset (asynchronous, on rst high): state=IDLE, acc=0, beats=0, ovf=0, mode_err=0, out_valid=0, in_ready=1, latched mode=0. Reset mid-vector discards all partial state.
- A beat is accepted when in_valid and in_ready are both 1 on a clock edge. No other condition counts as acceptance.
- All inputs are unsigned. The selected lane sum is zero-extended to ACC_W + 1 bits before the add.
- States:
  - IDLE: in_ready=1, out_valid=0. On an accepted beat:
    - latch mode;
    - acc = ext(selected);
    - beats = 1;
    - ovf = 0;
    - mode_err = (mode > 4);
    - next state is DONE if in_last is 1, otherwise ACC.
  - ACC: in_ready=1, out_valid=0. On an accepted beat:
    - acc = (acc + ext(selected)) mod 2^ACC_W, where selection uses the latched mode, not the mode port;
    - ovf |= carry out of bit ACC_W-1;
    - beats increments and saturates at 2^CNT_W-1;
    - next state is DONE if in_last is 1.
    - With no accepted beat, all state holds.
  - DONE: out_valid=1, in_ready=0. acc_out, beats, ovf and mode_err stay stable until out_ready is 1. On an edge with out_ready=1, the state goes to IDLE and acc, beats, ovf and mode_err clear to 0.
- An illegal latched mode (5-7) contributes 0 on every beat of the vector. The vector still completes normally.
- Latency: out_valid rises on the edge that accepts the last beat, so it is visible in the following cycle. There is one bubble cycle after result acceptance before the next beat can be taken.
- acc_out, beats, ovf and mode_err are driven from registers at all times. They are meaningful only when out_valid is 1.
- in_last is ignored when in_valid is 0.
- Mode changes while in ACC have no effect.

Test Plan:
1. mode=0, one beat with mul_int32=64'hFFFFFFFE00000001 and in_last=1 -> next cycle out_valid=1, acc_out=72'h00FFFFFFFE00000001, beats=1, ovf=0.
2. mode=4, three beats with sum_int2=8'h90, last on beat 3 -> acc_out=432 (0x1B0), beats=3. in_ready=0 while out_valid=1.
3. Backpressure on scenario 2: out_ready held 0 for 5 cycles -> acc_out, beats and out_valid stay stable, no beat is accepted. out_ready=1 -> IDLE the next cycle with acc=0.
4. ACC_W=64, mode=0, two beats of 64'hFFFFFFFE00000001 -> acc_out=64'hFFFFFFFC00000002, ovf=1.
5. Beat 1: mode=2, sum_int8=18'h3F804. Beat 2: mode port set to 1, sum_int8=18'h3F804, sum_int16=33'h1FFFC0002, last -> acc_out=0x7F008 (the latched int8 mode is used).
6. rst pulsed mid-vector after 2 beats, then mode=3 with one last beat of sum_int4=11'h708 -> acc_out=0x708, beats=1, ovf=0. Also mode=6 for one beat -> acc_out=0, mode_err=1.
